// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with PC, req/ready instruction-memory handshake and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch/bubble performance counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        PcWrite_i,
    input  logic        Stall_i,
    input  logic        Flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] IF_ID_pc_o,
    output logic [31:0] IF_ID_instr_o,
    output logic        IF_ID_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count_o,
    output logic [31:0] bubble_count_o
`endif
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] holdInstr_q, holdInstr_d;
    logic [31:0] target_q, target_d;
    logic        drop_q, drop_d;
    logic [31:0] ifIdPc_q, ifIdPc_d;
    logic [31:0] ifIdInstr_q, ifIdInstr_d;
    logic        ifIdValid_q, ifIdValid_d;
    logic        ifIdLoad;
    logic        consume;
    logic [31:0] pcPlus4;

    assign consume = !Stall_i && PcWrite_i;
    assign pcPlus4 = pc_q + 32'd4;

    // The drop flag keeps the stale request asserted until its response is swallowed.
    assign imem_req_o    = (state_q == StFetch) || drop_q;
    assign imem_addr_o   = pc_q;
    assign IF_ID_pc_o    = ifIdPc_q;
    assign IF_ID_instr_o = ifIdInstr_q;
    assign IF_ID_valid_o = ifIdValid_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        holdInstr_d = holdInstr_q;
        target_d    = target_q;
        drop_d      = drop_q;
        ifIdLoad    = 1'b0;
        ifIdPc_d    = pc_q;
        ifIdInstr_d = NOP_INSTR;
        ifIdValid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StFetch;
            end
            StFetch: begin
                if (Flush_i) begin
                    ifIdLoad = 1'b1;
                    ifIdPc_d = '0;
                    if (!imem_ready_i) begin
                        target_d = branch_target_i;
                        drop_d   = 1'b1;
                        state_d  = StDrain;
                    end else begin
                        pc_d = branch_target_i;
                    end
                end else if (imem_ready_i && consume) begin
                    ifIdLoad    = 1'b1;
                    ifIdInstr_d = imem_data_i;
                    ifIdValid_d = 1'b1;
                    pc_d        = pcPlus4;
                end else begin
                    if (imem_ready_i) begin
                        holdInstr_d = imem_data_i;
                        state_d     = StHold;
                    end
                    ifIdLoad = !Stall_i;
                end
            end
            StHold: begin
                if (Flush_i) begin
                    ifIdLoad = 1'b1;
                    ifIdPc_d = '0;
                    pc_d     = branch_target_i;
                    state_d  = StFetch;
                end else if (consume) begin
                    ifIdLoad    = 1'b1;
                    ifIdInstr_d = holdInstr_q;
                    ifIdValid_d = 1'b1;
                    pc_d        = pcPlus4;
                    state_d     = StFetch;
                end else begin
                    ifIdLoad = !Stall_i;
                end
            end
            StDrain: begin
                if (Flush_i) begin
                    ifIdLoad = 1'b1;
                    ifIdPc_d = '0;
                    target_d = branch_target_i;
                end
                // A flush coinciding with the stale response redirects straight to the newest target.
                if (imem_ready_i) begin
                    drop_d  = 1'b0;
                    pc_d    = Flush_i ? branch_target_i : target_q;
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            holdInstr_q <= '0;
            target_q    <= '0;
            drop_q      <= 1'b0;
            ifIdPc_q    <= '0;
            ifIdInstr_q <= NOP_INSTR;
            ifIdValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            holdInstr_q <= holdInstr_d;
            target_q    <= target_d;
            drop_q      <= drop_d;
            if (ifIdLoad) begin
                ifIdPc_q    <= ifIdPc_d;
                ifIdInstr_q <= ifIdInstr_d;
                ifIdValid_q <= ifIdValid_d;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchCnt_q;
    logic [31:0] bubbleCnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetchCnt_q  <= '0;
            bubbleCnt_q <= '0;
        end else if (ifIdLoad) begin
            if (ifIdValid_d) fetchCnt_q <= fetchCnt_q + 32'd1;
            else             bubbleCnt_q <= bubbleCnt_q + 32'd1;
        end
    end

    assign fetch_count_o  = fetchCnt_q;
    assign bubble_count_o = bubbleCnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: random hazards, flushes, resets and memory latency
// against a program-order model of the instruction stream.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        PcWrite_i = 1'b1;
    logic        Stall_i = 1'b0;
    logic        Flush_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic [31:0] IF_ID_pc_o;
    logic [31:0] IF_ID_instr_o;
    logic        IF_ID_valid_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_o;
    logic [31:0] bubble_count_o;
`endif

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .PcWrite_i      (PcWrite_i),
        .Stall_i        (Stall_i),
        .Flush_i        (Flush_i),
        .branch_target_i(branch_target_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ready_i   (imem_ready_i),
        .imem_data_i    (imem_data_i),
        .IF_ID_pc_o     (IF_ID_pc_o),
        .IF_ID_instr_o  (IF_ID_instr_o),
        .IF_ID_valid_o  (IF_ID_valid_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count_o  (fetch_count_o),
        .bubble_count_o (bubble_count_o)
`endif
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          entries = 0;
    logic [31:0] expQ[$];
    logic [31:0] nextPc = RESET_PC;
    int          minLat = 0;
    int          maxLat = 0;
    int          waitCnt = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected program-order PCs: a segment starts at reset or a branch target.
    task automatic newSegment(input logic [31:0] base);
        expQ.delete();
        nextPc = base;
    endtask

    task automatic topUp();
        while (expQ.size() < 16) begin
            expQ.push_back(nextPc);
            nextPc = nextPc + 32'd4;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    // Memory responder with a programmable wait-state count per request.
    always @(negedge clk) begin
        if (imem_req_o) begin
            if (waitCnt == 0) begin
                imem_ready_i = 1'b1;
                imem_data_i  = memWord(imem_addr_o);
                waitCnt      = int'($urandom_range(maxLat, minLat));
            end else begin
                imem_ready_i = 1'b0;
                imem_data_i  = 32'hDEAD_BEEF;
                waitCnt--;
            end
        end else begin
            imem_ready_i = 1'b0;
        end
    end

    logic        prevReq = 1'b0;
    logic [31:0] prevAddr = '0;
    logic [31:0] prevPc = '0;
    logic [31:0] prevInstr = '0;
    logic        prevValid = 1'b0;

    // Monitor: inputs read here are those that were applied at the edge just taken.
    always @(posedge clk) begin
        #1;
        if (rst_i) begin
            check32("rst_req", {31'd0, imem_req_o}, 32'd0);
            check32("rst_addr", imem_addr_o, RESET_PC);
            check32("rst_ifid_pc", IF_ID_pc_o, 32'd0);
            check32("rst_ifid_instr", IF_ID_instr_o, NOP);
            check32("rst_ifid_valid", {31'd0, IF_ID_valid_o}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
            check32("rst_fetch_cnt", fetch_count_o, 32'd0);
            check32("rst_bubble_cnt", bubble_count_o, 32'd0);
`endif
        end else begin
            if (prevReq && !imem_ready_i) check32("addr_stable", imem_addr_o, prevAddr);
            if (Flush_i) begin
                check32("flush_pc", IF_ID_pc_o, 32'd0);
                check32("flush_instr", IF_ID_instr_o, NOP);
                check32("flush_valid", {31'd0, IF_ID_valid_o}, 32'd0);
            end else if (Stall_i) begin
                check32("stall_pc", IF_ID_pc_o, prevPc);
                check32("stall_instr", IF_ID_instr_o, prevInstr);
                check32("stall_valid", {31'd0, IF_ID_valid_o}, {31'd0, prevValid});
            end else if (!PcWrite_i) begin
                check32("nopcw_valid", {31'd0, IF_ID_valid_o}, 32'd0);
                check32("nopcw_instr", IF_ID_instr_o, NOP);
            end else if (IF_ID_valid_o) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL exp_queue: got pc %h, expected queue empty", IF_ID_pc_o);
                end else begin
                    logic [31:0] ePc;
                    ePc = expQ.pop_front();
                    check32("entry_pc", IF_ID_pc_o, ePc);
                    check32("entry_instr", IF_ID_instr_o, memWord(ePc));
                    entries++;
                end
            end else begin
                check32("bubble_instr", IF_ID_instr_o, NOP);
            end
        end
        prevReq   = imem_req_o;
        prevAddr  = imem_addr_o;
        prevPc    = IF_ID_pc_o;
        prevInstr = IF_ID_instr_o;
        prevValid = IF_ID_valid_o;
    end

    // Reset for one edge, then start; returns one cycle after the start edge.
    task automatic doReset();
        rst_i   = 1'b1;
        Flush_i = 1'b0;
        start_i = 1'b0;
        newSegment(RESET_PC);
        topUp();
        cycle();
        rst_i   = 1'b0;
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        topUp();
    endtask

    initial begin
        bit found;
        // Zero-wait memory, no hazards: one instruction per cycle.
        minLat = 0;
        maxLat = 0;
        waitCnt = 0;
        cycle();
        doReset();
        repeat (16) begin
            cycle();
            topUp();
        end
        check32("zero_wait_rate", entries, 16);

        // Random hazards, flushes, resets and memory latency.
        for (int i = 0; i < 4000; i++) begin
            maxLat = (i / 500) % 4;
            if ($urandom_range(0, 399) == 0) begin
                doReset();
            end else begin
                Stall_i   = ($urandom_range(0, 3) == 0);
                PcWrite_i = ($urandom_range(0, 4) != 0);
                if ($urandom_range(0, 14) == 0) begin
                    Flush_i = 1'b1;
                    if ($urandom_range(0, 5) == 0) branch_target_i = 32'hFFFF_FFF0;
                    else branch_target_i = 32'($urandom_range(0, 1023)) << 2;
                    newSegment(branch_target_i);
                end else begin
                    Flush_i = 1'b0;
                end
                topUp();
                cycle();
            end
        end
        vectors++;
        if (entries < 200) begin
            miscompares++;
            $display("FAIL progress: got %0d entries, expected at least 200", entries);
        end

        // Flush into DRAIN on a slow request, then reset mid-drain.
        Stall_i   = 1'b0;
        PcWrite_i = 1'b1;
        Flush_i   = 1'b0;
        cycle();
        minLat  = 3;
        maxLat  = 3;
        waitCnt = 3;
        doReset();
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (imem_req_o && !imem_ready_i) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL drain_setup: got no waiting request, expected one within 10 cycles");
        end
        Flush_i = 1'b1;
        branch_target_i = 32'h0000_0100;
        newSegment(branch_target_i);
        topUp();
        cycle();
        Flush_i = 1'b0;
        check32("drain_req", {31'd0, imem_req_o}, 32'd1);
        check32("drain_stale_addr", imem_addr_o, RESET_PC);
        check32("drain_valid", {31'd0, IF_ID_valid_o}, 32'd0);
        rst_i = 1'b1;
        newSegment(RESET_PC);
        topUp();
        cycle();
        check32("post_rst_req", {31'd0, imem_req_o}, 32'd0);
        check32("post_rst_addr", imem_addr_o, RESET_PC);
        rst_i = 1'b0;
        repeat (4) cycle();
        check32("idle_req", {31'd0, imem_req_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
